// File: rtl/alu_arbiter_if.sv
// Bundles the requester, response and ALU-side signals of the ALU arbiter.
// The slave modport is the arbiter. The master modport is the surrounding
// environment: the two requesters together with the shared ALU.
interface alu_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [3:0]       req_op0;
    logic [3:0]       req_op1;
    logic             req_fw0;
    logic             req_fw1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [WIDTH-1:0] alu_reg1;
    logic [WIDTH-1:0] alu_reg2;
    logic [3:0]       alu_inst;
    logic             alu_flag_write;
    logic [WIDTH-1:0] alu_result;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1,
               req_op0, req_op1, req_fw0, req_fw1, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_result,
               alu_reg1, alu_reg2, alu_inst, alu_flag_write
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1,
               req_op0, req_op1, req_fw0, req_fw1, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_result,
               alu_reg1, alu_reg2, alu_inst, alu_flag_write
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// One transaction at a time: accept in IDLE, one EXEC cycle with the
// operands registered onto the ALU, then a held response in RESP.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    alu_arbiter_if.slave      bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             owner_q;
    logic             last_grant_q;
    logic             fw_q;
    logic             winner;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_op;
    logic             sel_fw;

    assign busy = (state_q != IDLE);

    // Pick the winner: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        winner = 1'b0;
        case (bus.req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant_q;
            default: winner = 1'b0;
        endcase
        sel_a  = winner ? bus.req_a1  : bus.req_a0;
        sel_b  = winner ? bus.req_b1  : bus.req_b0;
        sel_op = winner ? bus.req_op1 : bus.req_op0;
        sel_fw = winner ? bus.req_fw1 : bus.req_fw0;
    end

    // Next-state and handshake outputs; every output is forced idle while reset is low.
    always_comb begin
        state_d            = state_q;
        accept             = 1'b0;
        bus.req_ready      = 2'b00;
        bus.rsp_valid      = 2'b00;
        bus.alu_flag_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    bus.req_ready = winner ? 2'b10 : 2'b01;
                    accept        = 1'b1;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                bus.alu_flag_write = fw_q;
                state_d            = RESP;
            end
            RESP: begin
                bus.rsp_valid = owner_q ? 2'b10 : 2'b01;
                if (bus.rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!reset) begin
            accept             = 1'b0;
            bus.req_ready      = 2'b00;
            bus.rsp_valid      = 2'b00;
            bus.alu_flag_write = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture on accept, result capture and fairness update at the end of EXEC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.alu_reg1   <= '0;
            bus.alu_reg2   <= '0;
            bus.alu_inst   <= 4'b0000;
            bus.rsp_result <= '0;
            fw_q           <= 1'b0;
            owner_q        <= 1'b0;
            last_grant_q   <= 1'b1;
        end else begin
            if (accept) begin
                bus.alu_reg1 <= sel_a;
                bus.alu_reg2 <= sel_b;
                bus.alu_inst <= sel_op;
                fw_q         <= sel_fw;
                owner_q      <= winner;
            end
            if (state_q == EXEC) begin
                bus.rsp_result <= bus.alu_result;
                last_grant_q   <= owner_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int WIDTH = 16;

    logic clk;
    logic reset;
    logic busy;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state: one outstanding transaction at most.
    bit               m_busy  = 0;
    int               m_age   = 0;
    int               m_owner = 0;
    int               m_last  = 1;
    bit               m_fw    = 0;
    logic [WIDTH-1:0] m_a, m_b, m_res;
    logic [3:0]       m_op;

    int g_who[$];
    int g_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU behaviour: op[2:0] selects the operation, op[3] turns add into subtract.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [3:0] op);
        logic [2*WIDTH-1:0] p;
        p = a * b;
        case (op[2:0])
            3'd0:    return op[3] ? a - b : a + b;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return p[WIDTH-1:0];
            default: return '0;
        endcase
    endfunction

    // The ALU itself lives in the bench.
    always_comb bus.alu_result = alu_fn(bus.alu_reg1, bus.alu_reg2, bus.alu_inst);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Round-robin choice: -1 when nobody asks.
    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return (last == 0) ? 1 : 0;
    endfunction

    // One clock cycle: inputs are already driven (at the falling edge).
    task automatic tick();
        logic [1:0] e_rdy, e_rsp;
        logic       e_fw;
        int         w;
        bit         hs, rst_s, rr_own;
        #1;
        e_rdy = 2'b00; e_rsp = 2'b00; e_fw = 1'b0; hs = 0; w = -1;
        rst_s  = reset;
        rr_own = bus.rsp_ready[m_owner];
        if (rst_s) begin
            if (!m_busy) begin
                w = pick(bus.req_valid, m_last);
                if (w >= 0) begin
                    e_rdy = (w == 1) ? 2'b10 : 2'b01;
                    hs    = 1;
                end
            end else if (m_age == 1) begin
                e_fw = m_fw;
            end else begin
                e_rsp = (m_owner == 1) ? 2'b10 : 2'b01;
            end
        end
        check("req_ready", bus.req_ready, e_rdy);
        check("rsp_valid", bus.rsp_valid, e_rsp);
        check("flag_write", bus.alu_flag_write, e_fw);
        check("busy", busy, m_busy);
        if (rst_s && m_busy && m_age == 1) begin
            check("alu_reg1", bus.alu_reg1, m_a);
            check("alu_reg2", bus.alu_reg2, m_b);
            check("alu_inst", bus.alu_inst, m_op);
        end
        if (rst_s && m_busy && m_age >= 2)
            check("rsp_result", bus.rsp_result, m_res);
        if (bus.req_ready == 2'b01) begin g_who.push_back(0); g_cyc.push_back(cyc); end
        if (bus.req_ready == 2'b10) begin g_who.push_back(1); g_cyc.push_back(cyc); end
        if (hs) begin
            m_a   = (w == 1) ? bus.req_a1  : bus.req_a0;
            m_b   = (w == 1) ? bus.req_b1  : bus.req_b0;
            m_op  = (w == 1) ? bus.req_op1 : bus.req_op0;
            m_fw  = (w == 1) ? bus.req_fw1 : bus.req_fw0;
            m_res = alu_fn(m_a, m_b, m_op);
        end
        @(posedge clk);
        if (!rst_s) begin
            m_busy = 0;
            m_last = 1;
        end else if (hs) begin
            m_busy  = 1;
            m_age   = 1;
            m_owner = w;
        end else if (m_busy && m_age == 1) begin
            m_age  = 2;
            m_last = m_owner;
        end else if (m_busy && rr_own) begin
            m_busy = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = 4'd0; bus.req_fw0 = 1'b0;
        bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = 4'd0; bus.req_fw1 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_reg1", bus.alu_reg1, 16'h0000);
        check("rst_reg2", bus.alu_reg2, 16'h0000);
        check("rst_inst", bus.alu_inst, 4'b0000);
        check("rst_result", bus.rsp_result, 16'h0000);
        check("rst_fw", bus.alu_flag_write, 1'b0);
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = 2'b00;

        // Add from requester 0
        bus.req_a0 = 16'h1234; bus.req_b0 = 16'h0F0F; bus.req_op0 = 4'b0000; bus.req_fw0 = 1'b0;
        bus.req_valid = 2'b01;
        #1 check("add_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        #1 check("add_fw", bus.alu_flag_write, 1'b0);
        tick();
        #1;
        check("add_rsp_valid", bus.rsp_valid, 2'b01);
        check("add_result", bus.rsp_result, 16'h2143);
        check("add_fw_resp", bus.alu_flag_write, 1'b0);
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;

        // Subtract with flag update from requester 1
        bus.req_a1 = 16'd5; bus.req_b1 = 16'd7; bus.req_op1 = 4'b1000; bus.req_fw1 = 1'b1;
        bus.req_valid = 2'b10;
        #1 check("sub_fw_idle", bus.alu_flag_write, 1'b0);
        tick();
        bus.req_valid = 2'b00;
        #1 check("sub_fw_exec", bus.alu_flag_write, 1'b1);
        tick();
        #1;
        check("sub_fw_resp", bus.alu_flag_write, 1'b0);
        check("sub_rsp_valid", bus.rsp_valid, 2'b10);
        check("sub_result", bus.rsp_result, 16'hFFFE);
        bus.rsp_ready = 2'b10;
        tick();

        // Contention: both valid, responses always accepted
        g_who.delete(); g_cyc.delete();
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        for (int i = 0; i < 12; i++) begin
            bus.req_a0 = 16'($urandom); bus.req_b0 = 16'($urandom);
            bus.req_a1 = 16'($urandom); bus.req_b1 = 16'($urandom);
            tick();
        end
        bus.req_valid = 2'b00;
        check("cont_grants", g_who.size(), 4);
        for (int i = 0; i < 4; i++)
            check("cont_order", (i < g_who.size()) ? g_who[i] : -1, i % 2);
        for (int i = 1; i < 4; i++)
            check("cont_spacing", (i < g_cyc.size()) ? g_cyc[i] - g_cyc[i-1] : -1, 3);

        // Backpressure: mul held for five cycles, competing requests must wait
        bus.rsp_ready = 2'b00;
        bus.req_a0 = 16'h0003; bus.req_b0 = 16'h0005; bus.req_op0 = 4'b0100; bus.req_fw0 = 1'b0;
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_result", bus.rsp_result, 16'h000F);
            check("bp_rsp_valid", bus.rsp_valid, 2'b01);
            check("bp_no_grant", bus.req_ready, 2'b00);
            bus.rsp_ready = 2'b10;
            tick();
        end
        bus.rsp_ready = 2'b01;
        bus.req_valid = 2'b00;
        tick();
        bus.rsp_ready = 2'b00;
        #1 check("bp_idle", busy, 1'b0);

        // Reset during EXEC of a flag-writing op
        bus.req_a1 = 16'h00AA; bus.req_b1 = 16'h0055; bus.req_op1 = 4'b0000; bus.req_fw1 = 1'b1;
        bus.req_valid = 2'b10;
        tick();
        bus.req_valid = 2'b00;
        reset = 1'b0;
        #1 check("rstop_fw_drop", bus.alu_flag_write, 1'b0);
        tick();
        reset = 1'b1;
        bus.rsp_ready = 2'b11;
        #1;
        check("rstop_busy", busy, 1'b0);
        check("rstop_rsp_valid", bus.rsp_valid, 2'b00);
        check("rstop_reg1", bus.alu_reg1, 16'h0000);
        check("rstop_inst", bus.alu_inst, 4'b0000);
        check("rstop_result", bus.rsp_result, 16'h0000);
        tick();
        tick();
        bus.req_valid = 2'b11;
        #1 check("rstop_tie_to_0", bus.req_ready, 2'b01);
        bus.req_valid = 2'b00;
        tick();

        // Undefined opcode returns zero
        bus.req_a0 = 16'hFFFF; bus.req_b0 = 16'hFFFF; bus.req_op0 = 4'b0101;
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        tick();
        #1;
        check("undef_rsp_valid", bus.rsp_valid, 2'b01);
        check("undef_result", bus.rsp_result, 16'h0000);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            bus.rsp_ready = 2'($urandom_range(0, 3));
            bus.req_a0 = 16'($urandom); bus.req_b0 = 16'($urandom);
            bus.req_a1 = 16'($urandom); bus.req_b1 = 16'($urandom);
            bus.req_op0 = 4'($urandom_range(0, 15)); bus.req_op1 = 4'($urandom_range(0, 15));
            bus.req_fw0 = 1'($urandom_range(0, 1)); bus.req_fw1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) reset = 1'b0;
            else reset = 1'b1;
            tick();
        end
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        repeat (4) tick();
        #1 check("final_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single ALU instance between two requesters, for example the CPU execute stage (port 0) and an auxiliary engine (port 1). Arbitration is round-robin. Operands are accepted through a valid/ready handshake and registered onto the ALU inputs for exactly one execute cycle. The result is returned to the winning requester through a held response handshake. The block is the only driver of the ALU `reg1`, `reg2`, `inst` and `flagWrite` inputs.

## Interface
- `WIDTH`, 16, datapath width; must match the ALU instance.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2  per-requester grant/accept; at most one bit set.
- `req_a0`, `req_b0`  in  WIDTH each  requester 0 operands.
- `req_a1`, `req_b1`  in  WIDTH each  requester 1 operands.
- `req_op0`, `req_op1`  in  4 each  ALU opcode: bits [2:0] select the operation, bit 3 selects subtract.
- `req_fw0`, `req_fw1`  in  1 each  request a flag-register update for this operation.
- `rsp_valid`  out  2  one-hot response valid to the owning requester.
- `rsp_ready`  in  2  per-requester response accept.
- `rsp_result`  out  WIDTH  shared response data; meaningful only while a `rsp_valid` bit is set.
- `alu_reg1`, `alu_reg2`  out  WIDTH each  to ALU `reg1`/`reg2`.
- `alu_inst`  out  4  to ALU `inst`.
- `alu_flag_write`  out  1  to ALU `flagWrite`.
- `alu_result`  in  WIDTH  from ALU `result`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - If no `req_valid` bit is set, stay in IDLE.
  - If exactly one bit is set, that requester wins.
  - If both bits are set, the winner is the requester not recorded in `last_grant`.
  - `req_ready[winner]` is driven combinationally in IDLE only.
  - On `req_valid & req_ready`:
    - latch a/b/op/fw into `alu_reg1`/`alu_reg2`/`alu_inst`/`fw_q`;
    - latch the owner id;
    - go to EXEC.
- **EXEC** (always exactly one cycle)
  - `alu_flag_write = fw_q` during this cycle only.
  - At the end of the cycle: `rsp_result <= alu_result`, `last_grant <= owner`, go to RESP.
- **RESP**
  - `rsp_valid[owner] = 1` and `rsp_result` holds stable.
  - On `rsp_ready[owner]`, go to IDLE. No new request is accepted in the same cycle.
  - `rsp_ready` on the non-owner port is ignored.
- ALU operands and opcode are registered outputs. They hold their last value outside EXEC. Only `alu_flag_write` is gated to EXEC.
- Opcodes are passed through unchecked. Ops `3'b101`–`3'b111` return 0, because that is the ALU's behaviour.
- A requester may deassert `req_valid` before it is granted. No transaction occurs unless valid and ready coincide in IDLE.
- Reset values:
  - state = IDLE;
  - `alu_reg1`, `alu_reg2`, `rsp_result` = 0;
  - `alu_inst` = 4'b0000;
  - `fw_q`, `alu_flag_write` = 0;
  - `rsp_valid`, `req_ready` = 0;
  - `last_grant` = 1, so requester 0 wins the first tie.
- Reset asserted in EXEC or RESP aborts the operation:
  - no response is issued;
  - `alu_flag_write` drops in the same cycle that reset is sampled;
  - a flag update already performed by the ALU on that cycle's falling edge is not undone.

## Timing
- Cycle N: handshake accepted in IDLE.
- Cycle N+1: EXEC. ALU inputs are stable from the rising edge. The ALU samples flags on the falling edge mid-cycle.
- Cycle N+2: RESP with `rsp_valid` high. The earliest return to IDLE is N+3.
- Latency: 2 cycles from handshake to `rsp_valid`.
- Maximum throughput: one operation per 3 cycles when `rsp_ready` is held high.
- Backpressure: RESP holds indefinitely. `rsp_result` and `rsp_valid` do not change while `rsp_ready[owner]` is low.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…

## Test plan
- Add:
  - stimulus: after reset, requester 0 sends a=0x1234, b=0x0F0F, op=4'b0000, fw=0;
  - response: `req_ready[0]` in cycle N, `alu_flag_write` never high, `rsp_valid=2'b01` at N+2, `rsp_result=0x2143`.
- Subtract with flags:
  - stimulus: requester 1 sends a=5, b=7, op=4'b1000, fw=1;
  - response: `alu_flag_write` high for exactly the EXEC cycle, `rsp_result=0xFFFE`, `rsp_valid=2'b10`.
- Contention:
  - stimulus: both requesters hold valid for 4 operations with `rsp_ready=2'b11`;
  - response: grant order 0,1,0,1, a new handshake every 3 cycles, `req_ready` never 2'b11.
- Backpressure:
  - stimulus: mul 0x0003×0x0005, with `rsp_ready` low for 5 cycles;
  - response: `rsp_result=0x000F` and `rsp_valid` stable for all 5 cycles, IDLE the cycle after accept, no grant while held.
- Reset mid-op:
  - stimulus: `reset` low during EXEC of an op with fw=1;
  - response: next cycle state=IDLE, all outputs at reset values, no `rsp_valid` ever issued.
- Undefined op:
  - stimulus: op=4'b0101, a=0xFFFF, b=0xFFFF;
  - response: `rsp_result=0x0000` after normal 2-cycle latency.
